// File: rtl/mips_alu.sv
// mips_alu: 32-bit MIPS-style integer ALU for the EXE stage.
// aluResult, HI_OUT and LO_OUT are combinational; Exception_OUT is the only state.
// Optional feature macro: ALU_MULDIV_EN enables MULT/MULTU/DIV/DIVU (codes 17-20).
// Without it those codes fall to the default (result 0, HI/LO pass-through).
module mips_alu (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [5:0]  ALU_control,
    input  logic [4:0]  shiftAmount,
    input  logic [31:0] HI_IN,
    input  logic [31:0] LO_IN,
    output logic [31:0] aluResult,
    output logic [31:0] HI_OUT,
    output logic [31:0] LO_OUT,
    output logic        Exception_OUT
);

    localparam logic [5:0] OpAnd  = 6'd0;
    localparam logic [5:0] OpOr   = 6'd1;
    localparam logic [5:0] OpAdd  = 6'd2;
    localparam logic [5:0] OpAddu = 6'd3;
    localparam logic [5:0] OpXor  = 6'd4;
    localparam logic [5:0] OpNor  = 6'd5;
    localparam logic [5:0] OpSub  = 6'd6;
    localparam logic [5:0] OpSubu = 6'd7;
    localparam logic [5:0] OpSlt  = 6'd8;
    localparam logic [5:0] OpSltu = 6'd9;
    localparam logic [5:0] OpSll  = 6'd10;
    localparam logic [5:0] OpSrl  = 6'd11;
    localparam logic [5:0] OpSra  = 6'd12;
    localparam logic [5:0] OpSllv = 6'd13;
    localparam logic [5:0] OpSrlv = 6'd14;
    localparam logic [5:0] OpSrav = 6'd15;
    localparam logic [5:0] OpLui  = 6'd16;
`ifdef ALU_MULDIV_EN
    localparam logic [5:0] OpMult  = 6'd17;
    localparam logic [5:0] OpMultu = 6'd18;
    localparam logic [5:0] OpDiv   = 6'd19;
    localparam logic [5:0] OpDivu  = 6'd20;
`endif
    localparam logic [5:0] OpMfhi = 6'd21;
    localparam logic [5:0] OpMflo = 6'd22;
    localparam logic [5:0] OpMthi = 6'd23;
    localparam logic [5:0] OpMtlo = 6'd24;

    logic [31:0] sum;
    logic [31:0] diff;
    logic        add_ovf;
    logic        sub_ovf;
    logic        exc_d;

    // Shared adder/subtractor and their signed-overflow detection.
    always_comb begin
        sum     = A + B;
        diff    = A - B;
        add_ovf = (A[31] == B[31]) && (sum[31] != A[31]);
        sub_ovf = (A[31] != B[31]) && (diff[31] != A[31]);
    end

`ifdef ALU_MULDIV_EN
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] prod;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic        div_signed;

    // Multiplier and divider datapath; signed division works on magnitudes so the
    // 0x80000000 / -1 case wraps naturally instead of hitting an overflowing divide.
    always_comb begin
        mul_a      = (ALU_control == OpMult) ? {{32{A[31]}}, A} : {32'b0, A};
        mul_b      = (ALU_control == OpMult) ? {{32{B[31]}}, B} : {32'b0, B};
        prod       = mul_a * mul_b;
        div_signed = (ALU_control == OpDiv);
        a_mag      = (div_signed && A[31]) ? (32'd0 - A) : A;
        b_mag      = (div_signed && B[31]) ? (32'd0 - B) : B;
        q_mag      = '0;
        r_mag      = '0;
        if (b_mag != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        div_q = (div_signed && (A[31] ^ B[31])) ? (32'd0 - q_mag) : q_mag;
        div_r = (div_signed && A[31]) ? (32'd0 - r_mag) : r_mag;
    end
`endif

    // Result and next-HI/LO selection; every code not decoded passes HI/LO through.
    always_comb begin
        aluResult = '0;
        HI_OUT    = HI_IN;
        LO_OUT    = LO_IN;
        exc_d     = 1'b0;
        case (ALU_control)
            OpAnd:  aluResult = A & B;
            OpOr:   aluResult = A | B;
            OpXor:  aluResult = A ^ B;
            OpNor:  aluResult = ~(A | B);
            OpAdd:  begin
                aluResult = sum;
                exc_d     = add_ovf;
            end
            OpAddu: aluResult = sum;
            OpSub:  begin
                aluResult = diff;
                exc_d     = sub_ovf;
            end
            OpSubu: aluResult = diff;
            OpSlt:  aluResult = {31'b0, ($signed(A) < $signed(B))};
            OpSltu: aluResult = {31'b0, (A < B)};
            OpSll:  aluResult = B << shiftAmount;
            OpSrl:  aluResult = B >> shiftAmount;
            OpSra:  aluResult = $signed(B) >>> shiftAmount;
            OpSllv: aluResult = B << A[4:0];
            OpSrlv: aluResult = B >> A[4:0];
            OpSrav: aluResult = $signed(B) >>> A[4:0];
            OpLui:  aluResult = {B[15:0], 16'h0000};
`ifdef ALU_MULDIV_EN
            OpMult, OpMultu: begin
                HI_OUT = prod[63:32];
                LO_OUT = prod[31:0];
            end
            OpDiv, OpDivu: begin
                if (B == 32'd0) begin
                    exc_d = 1'b1;
                end else begin
                    HI_OUT = div_r;
                    LO_OUT = div_q;
                end
            end
`endif
            OpMfhi: aluResult = HI_IN;
            OpMflo: aluResult = LO_IN;
            OpMthi: HI_OUT = A;
            OpMtlo: LO_OUT = A;
            default: ;
        endcase
    end

    // Exception flag reflects the previous cycle's inputs only; reset clears it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            Exception_OUT <= 1'b0;
        end else begin
            Exception_OUT <= exc_d;
        end
    end

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu against a behavioural arithmetic model.
// Build with +define+ALU_MULDIV_EN to exercise the multiply/divide codes.
module tb_mips_alu;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] A;
    logic [31:0] B;
    logic [5:0]  ALU_control;
    logic [4:0]  shiftAmount;
    logic [31:0] HI_IN;
    logic [31:0] LO_IN;
    logic [31:0] aluResult;
    logic [31:0] HI_OUT;
    logic [31:0] LO_OUT;
    logic        Exception_OUT;

    int tests = 0;
    int fails = 0;

    mips_alu dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .A            (A),
        .B            (B),
        .ALU_control  (ALU_control),
        .shiftAmount  (shiftAmount),
        .HI_IN        (HI_IN),
        .LO_IN        (LO_IN),
        .aluResult    (aluResult),
        .HI_OUT       (HI_OUT),
        .LO_OUT       (LO_OUT),
        .Exception_OUT(Exception_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] r;
        logic [31:0] h;
        logic [31:0] l;
        logic        e;
    } vec_t;

    // Reference model: plain 64-bit integer arithmetic on the instruction semantics.
    task automatic ref_alu(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input logic [31:0] hi, input logic [31:0] lo,
                           output logic [31:0] r, output logic [31:0] h,
                           output logic [31:0] l, output logic e);
        int ai;
        int bi;
        longint sa;
        longint sb;
        longint t;
        longint max_i;
        longint min_i;
        longint unsigned pu;
        ai = a;
        bi = b;
        sa = ai;
        sb = bi;
        max_i = 2147483647;
        min_i = -max_i - 1;
        r = 32'd0;
        h = hi;
        l = lo;
        e = 1'b0;
        case (c)
            6'd0:  r = a & b;
            6'd1:  r = a | b;
            6'd2:  begin t = sa + sb; r = t[31:0]; e = (t > max_i) || (t < min_i); end
            6'd3:  r = a + b;
            6'd4:  r = a ^ b;
            6'd5:  r = ~(a | b);
            6'd6:  begin t = sa - sb; r = t[31:0]; e = (t > max_i) || (t < min_i); end
            6'd7:  r = a - b;
            6'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
            6'd9:  r = (a < b) ? 32'd1 : 32'd0;
            6'd10: r = b << sh;
            6'd11: r = b >> sh;
            6'd12: r = bi >>> sh;
            6'd13: r = b << a[4:0];
            6'd14: r = b >> a[4:0];
            6'd15: r = bi >>> a[4:0];
            6'd16: r = b * 32'd65536;
`ifdef ALU_MULDIV_EN
            6'd17: begin t = sa * sb; h = t[63:32]; l = t[31:0]; end
            6'd18: begin pu = a; pu = pu * b; h = pu[63:32]; l = pu[31:0]; end
            6'd19: begin
                if (b == 32'd0) e = 1'b1;
                else begin
                    t = sa / sb;
                    l = t[31:0];
                    t = sa % sb;
                    h = t[31:0];
                end
            end
            6'd20: begin
                if (b == 32'd0) e = 1'b1;
                else begin l = a / b; h = a % b; end
            end
`endif
            6'd21: r = hi;
            6'd22: r = lo;
            6'd23: h = a;
            6'd24: l = a;
            default: ;
        endcase
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [31:0] hi, input logic [31:0] lo);
        ALU_control = c;
        A           = a;
        B           = b;
        shiftAmount = sh;
        HI_IN       = hi;
        LO_IN       = lo;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        drive(6'd2, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h0, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        tests++;
        if (Exception_OUT !== 1'b0) begin
            fails++;
            $display("FAIL reset_flag: got %b want 0", Exception_OUT);
        end
        tests++;
        if (aluResult !== 32'h8000_0000) begin
            fails++;
            $display("FAIL reset_comb: got %h want 80000000", aluResult);
        end
        RESET = 1'b0;
        drive(6'd3, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_directed();
        vec_t vq[$];
        vq.push_back('{6'd2, 32'h7FFFFFFF, 32'h1, 5'd0, 32'hAAAA0000, 32'hBBBB, 32'h80000000,
                       32'hAAAA0000, 32'hBBBB, 1'b1});
        vq.push_back('{6'd3, 32'h7FFFFFFF, 32'h1, 5'd0, 32'hAAAA0000, 32'hBBBB, 32'h80000000,
                       32'hAAAA0000, 32'hBBBB, 1'b0});
        vq.push_back('{6'd8, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 32'h2, 32'h1, 32'h1, 32'h2, 1'b0});
        vq.push_back('{6'd9, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 32'h2, 32'h0, 32'h1, 32'h2, 1'b0});
        vq.push_back('{6'd12, 32'h0, 32'h80000000, 5'd4, 32'h1, 32'h2, 32'hF8000000, 32'h1,
                       32'h2, 1'b0});
        vq.push_back('{6'd14, 32'h24, 32'h80000000, 5'd0, 32'h1, 32'h2, 32'h08000000, 32'h1,
                       32'h2, 1'b0});
        vq.push_back('{6'd6, 32'h80000000, 32'h1, 5'd0, 32'h3, 32'h4, 32'h7FFFFFFF, 32'h3,
                       32'h4, 1'b1});
`ifdef ALU_MULDIV_EN
        vq.push_back('{6'd17, 32'hFFFFFFFE, 32'h3, 5'd0, 32'h11, 32'h22, 32'h0, 32'hFFFFFFFF,
                       32'hFFFFFFFA, 1'b0});
        vq.push_back('{6'd18, 32'hFFFFFFFE, 32'h3, 5'd0, 32'h11, 32'h22, 32'h0, 32'h2,
                       32'hFFFFFFFA, 1'b0});
        vq.push_back('{6'd19, 32'hFFFFFFF9, 32'h2, 5'd0, 32'h11, 32'h22, 32'h0, 32'hFFFFFFFF,
                       32'hFFFFFFFD, 1'b0});
        vq.push_back('{6'd19, 32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h11, 32'h22, 32'h0, 32'h0,
                       32'h80000000, 1'b0});
        vq.push_back('{6'd20, 32'h5, 32'h0, 5'd0, 32'h11, 32'h22, 32'h0, 32'h11, 32'h22, 1'b1});
`else
        vq.push_back('{6'd17, 32'hFFFFFFFE, 32'h3, 5'd0, 32'h11, 32'h22, 32'h0, 32'h11, 32'h22,
                       1'b0});
        vq.push_back('{6'd20, 32'h5, 32'h0, 5'd0, 32'h11, 32'h22, 32'h0, 32'h11, 32'h22, 1'b0});
`endif
        vq.push_back('{6'd23, 32'hDEADBEEF, 32'h0, 5'd0, 32'h9, 32'h5, 32'h0, 32'hDEADBEEF,
                       32'h5, 1'b0});
        vq.push_back('{6'd22, 32'h0, 32'h0, 5'd0, 32'h9, 32'h1234, 32'h1234, 32'h9, 32'h1234,
                       1'b0});
        vq.push_back('{6'd63, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'h9, 32'h8, 32'h0, 32'h9,
                       32'h8, 1'b0});
        foreach (vq[i]) begin
            drive(vq[i].c, vq[i].a, vq[i].b, vq[i].sh, vq[i].hi, vq[i].lo);
            #1;
            tests++;
            if (aluResult !== vq[i].r || HI_OUT !== vq[i].h || LO_OUT !== vq[i].l) begin
                fails++;
                $display("FAIL directed[%0d] code %0d: got r=%h hi=%h lo=%h want r=%h hi=%h lo=%h",
                         i, vq[i].c, aluResult, HI_OUT, LO_OUT, vq[i].r, vq[i].h, vq[i].l);
            end
            @(posedge CLK);
            #1;
            tests++;
            if (Exception_OUT !== vq[i].e) begin
                fails++;
                $display("FAIL directed_exc[%0d] code %0d: got %b want %b",
                         i, vq[i].c, Exception_OUT, vq[i].e);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0]  c;
        logic [31:0] er;
        logic [31:0] eh;
        logic [31:0] el;
        logic        ee;
        for (int n = 0; n < 800; n++) begin
            c = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(25, 63)) : 6'($urandom_range(0, 24));
            drive(c, pick_operand(), pick_operand(), 5'($urandom), $urandom, $urandom);
            ref_alu(c, A, B, shiftAmount, HI_IN, LO_IN, er, eh, el, ee);
            #1;
            tests++;
            if (aluResult !== er || HI_OUT !== eh || LO_OUT !== el) begin
                fails++;
                $display("FAIL random code %0d A=%h B=%h sh=%0d: got r=%h hi=%h lo=%h want r=%h hi=%h lo=%h",
                         c, A, B, shiftAmount, aluResult, HI_OUT, LO_OUT, er, eh, el);
            end
            @(posedge CLK);
            #1;
            tests++;
            if (Exception_OUT !== ee) begin
                fails++;
                $display("FAIL random_exc code %0d A=%h B=%h: got %b want %b",
                         c, A, B, Exception_OUT, ee);
            end
        end
    endtask

    // Ops change every cycle; the flag must track exactly the previous cycle's op.
    task automatic test_back_to_back();
        logic [5:0]  c;
        logic [31:0] er;
        logic [31:0] eh;
        logic [31:0] el;
        logic        ee;
        logic        prev_e;
        logic [5:0]  ops[4];
        ops[0] = 6'd2;
        ops[1] = 6'd6;
        ops[2] = 6'd19;
        ops[3] = 6'd20;
        prev_e = 1'b0;
        drive(6'd3, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0);
        @(posedge CLK);
        #1;
        for (int n = 0; n < 60; n++) begin
            c = ops[$urandom_range(0, 3)];
            drive(c, pick_operand(), ($urandom_range(0, 2) == 0) ? 32'h0 : pick_operand(),
                  5'd0, $urandom, $urandom);
            ref_alu(c, A, B, shiftAmount, HI_IN, LO_IN, er, eh, el, ee);
            tests++;
            if (Exception_OUT !== prev_e) begin
                fails++;
                $display("FAIL b2b_latency step %0d: got %b want %b", n, Exception_OUT, prev_e);
            end
            @(posedge CLK);
            #1;
            prev_e = ee;
        end
        tests++;
        if (Exception_OUT !== prev_e) begin
            fails++;
            $display("FAIL b2b_last: got %b want %b", Exception_OUT, prev_e);
        end
    endtask

    task automatic test_reset_midop();
        RESET = 1'b1;
        drive(6'd6, 32'h8000_0000, 32'h1, 5'd0, 32'h0, 32'h0);
        #1;
        tests++;
        if (aluResult !== 32'h7FFF_FFFF) begin
            fails++;
            $display("FAIL midreset_comb: got %h want 7fffffff", aluResult);
        end
        for (int n = 0; n < 3; n++) begin
            @(posedge CLK);
            #1;
            tests++;
            if (Exception_OUT !== 1'b0) begin
                fails++;
                $display("FAIL midreset_hold cycle %0d: got %b want 0", n, Exception_OUT);
            end
        end
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        tests++;
        if (Exception_OUT !== 1'b1) begin
            fails++;
            $display("FAIL midreset_release: got %b want 1", Exception_OUT);
        end
    endtask

    initial begin
        RESET = 1'b1;
        drive(6'd0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0);
        @(negedge CLK);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
